fwd_hazard_ctrl: RTL and testbench

- Forwarding and hazard controller for the 5-stage pipeline CPU (IF/ID/EX/MEM/WB).
- Drives the 2-bit selectors of the two 32-bit 3:1 ALU-operand muxes. Selector encoding matches the mux: 00 = register-file operand, 01 = EX/MEM result, 10 = MEM/WB result.
- Holds its own shadow pipeline of destination-register records (EX, MEM, WB) to compute forwarding and load-use stalls.
- Selectors are registered so they are valid while the consumer instruction is in EX.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/fwd_hazard_ctrl_if.sv | 42 ++++
 rtl/fwd_select.sv | 28 ++
 rtl/fwd_hazard_ctrl.sv | 109 ++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: forwarding-mux codes, register address width,
// and the destination record tracked by the hazard controller's shadow pipeline.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } dest_rec_t;

    // A record produces register r only if it really writes and r is not the hardwired zero.
    function automatic logic rec_writes(input dest_rec_t rec,
                                        input logic [REG_ADDR_W-1:0] r,
                                        input logic [REG_ADDR_W-1:0] zero_reg);
        return rec.valid & rec.reg_write & (rec.rd == r) & (r != zero_reg);
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage request and forwarding/hazard response bundle for fwd_hazard_ctrl.
// Statistics counters appear only when FWD_HAZARD_STATS_EN is defined.
interface fwd_hazard_ctrl_if;
    import cpu_pkg::*;

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  flush;
    logic [1:0]            fwd_sel_a;
    logic [1:0]            fwd_sel_b;
    logic                  stall;
    logic                  bubble_ex;
`ifdef FWD_HAZARD_STATS_EN
    logic [31:0]           stat_stalls;
    logic [31:0]           stat_fwds;
`endif

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_mem_read, flush,
`ifdef FWD_HAZARD_STATS_EN
        input  stat_stalls, stat_fwds,
`endif
        input  fwd_sel_a, fwd_sel_b, stall, bubble_ex
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_mem_read, flush,
`ifdef FWD_HAZARD_STATS_EN
        output stat_stalls, stat_fwds,
`endif
        output fwd_sel_a, fwd_sel_b, stall, bubble_ex
    );

endinterface

// File: rtl/fwd_select.sv
// Picks the operand-mux code for one source register from the EX and MEM
// shadow records; the younger EX producer takes priority.
module fwd_select
    import cpu_pkg::*;
#(
    parameter logic [REG_ADDR_W-1:0] ZERO_REG = '0
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  use_rs,
    input  dest_rec_t             ex_rec,
    input  dest_rec_t             mem_rec,
    output logic [1:0]            sel
);

    // Load flags are irrelevant to source selection; only the stall logic needs them.
    logic unused_load_flags;
    assign unused_load_flags = ex_rec.mem_read ^ mem_rec.mem_read;

    always_comb begin
        sel = FWD_RF;
        if (use_rs && rec_writes(ex_rec, rs, ZERO_REG)) begin
            sel = FWD_EXMEM;
        end else if (use_rs && rec_writes(mem_rec, rs, ZERO_REG)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Define FWD_HAZARD_STATS_EN to add stall/forward event counters.
module fwd_hazard_ctrl #(
    parameter int                    REG_ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter logic [REG_ADDR_W-1:0] ZERO_REG   = '0
) (
    input  logic              clk,
    input  logic              rst,
    fwd_hazard_ctrl_if.slave  bus
);
    import cpu_pkg::*;

    dest_rec_t  ex_r;
    dest_rec_t  mem_r;
    dest_rec_t  wb_r;
    dest_rec_t  id_rec;
    logic       load_use;
    logic       stall;
    logic       bubble_ex;
    logic [1:0] sel_a_next;
    logic [1:0] sel_b_next;
    logic [1:0] fwd_sel_a;
    logic [1:0] fwd_sel_b;

    assign id_rec = '{valid:     bus.id_valid,
                      rd:        bus.id_rd,
                      reg_write: bus.id_reg_write,
                      mem_read:  bus.id_mem_read};

    // A load in EX cannot forward until it reaches MEM, so a dependent ID instruction waits one cycle.
    assign load_use = bus.id_valid & ex_r.mem_read &
                      ((bus.id_use_rs1 & rec_writes(ex_r, bus.id_rs1, ZERO_REG)) |
                       (bus.id_use_rs2 & rec_writes(ex_r, bus.id_rs2, ZERO_REG)));

    assign stall     = load_use & ~bus.flush;
    assign bubble_ex = stall | bus.flush;

    fwd_select #(.ZERO_REG(ZERO_REG)) u_sel_a (
        .rs      (bus.id_rs1),
        .use_rs  (bus.id_use_rs1),
        .ex_rec  (ex_r),
        .mem_rec (mem_r),
        .sel     (sel_a_next)
    );

    fwd_select #(.ZERO_REG(ZERO_REG)) u_sel_b (
        .rs      (bus.id_rs2),
        .use_rs  (bus.id_use_rs2),
        .ex_rec  (ex_r),
        .mem_rec (mem_r),
        .sel     (sel_b_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_r      <= '0;
            mem_r     <= '0;
            wb_r      <= '0;
            fwd_sel_a <= FWD_RF;
            fwd_sel_b <= FWD_RF;
        end else begin
            wb_r  <= mem_r;
            mem_r <= ex_r;
            if (bubble_ex) begin
                ex_r      <= '0;
                fwd_sel_a <= FWD_RF;
                fwd_sel_b <= FWD_RF;
            end else begin
                ex_r      <= id_rec;
                fwd_sel_a <= sel_a_next;
                fwd_sel_b <= sel_b_next;
            end
        end
    end

    // WB results reach consumers through the register file, so wb_r is tracked but not compared.
    logic unused_wb;
    assign unused_wb = ^wb_r;

    assign bus.fwd_sel_a = fwd_sel_a;
    assign bus.fwd_sel_b = fwd_sel_b;
    assign bus.stall     = stall;
    assign bus.bubble_ex = bubble_ex;

`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] stat_stalls;
    logic [31:0] stat_fwds;
    logic [1:0]  fwd_inc;

    assign fwd_inc = bubble_ex ? 2'd0
                   : ({1'b0, (sel_a_next != FWD_RF)} + {1'b0, (sel_b_next != FWD_RF)});

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stalls <= '0;
            stat_fwds   <= '0;
        end else begin
            if (stall) begin
                stat_stalls <= stat_stalls + 32'd1;
            end
            stat_fwds <= stat_fwds + {30'd0, fwd_inc};
        end
    end

    assign bus.stat_stalls = stat_stalls;
    assign bus.stat_fwds   = stat_fwds;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed, table-driven bench for fwd_hazard_ctrl: one ID instruction per cycle
// with hand-computed stall/bubble and captured selector values.
module tb_fwd_hazard_ctrl;

    logic clk;
    logic rst;
    int   num_checks;
    int   num_fails;

    fwd_hazard_ctrl_if bus ();

    fwd_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       id_valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       flush;
        logic       exp_stall;
        logic       exp_bubble;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic v,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic rw, input logic mr, input logic fl,
                                input logic st, input logic bu,
                                input logic [1:0] a, input logic [1:0] b);
        vec_t t;
        t.name = name; t.id_valid = v; t.rs1 = rs1; t.rs2 = rs2;
        t.use1 = u1; t.use2 = u2; t.rd = rd; t.rw = rw; t.mr = mr; t.flush = fl;
        t.exp_stall = st; t.exp_bubble = bu; t.exp_a = a; t.exp_b = b;
        return t;
    endfunction

    task automatic applyStimulus(input vec_t t);
        bus.id_valid     = t.id_valid;
        bus.id_rs1       = t.rs1;
        bus.id_rs2       = t.rs2;
        bus.id_use_rs1   = t.use1;
        bus.id_use_rs2   = t.use2;
        bus.id_rd        = t.rd;
        bus.id_reg_write = t.rw;
        bus.id_mem_read  = t.mr;
        bus.flush        = t.flush;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        num_checks = 0;
        num_fails  = 0;

        // name, valid, rs1, rs2, use1, use2, rd, rw, mr, flush, stall, bubble, sel_a, sel_b
        vecs.push_back(mk("add_r3",      1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk("sub_use_r3",  1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 0, 2'b01, 2'b00));
        vecs.push_back(mk("nop_a",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk("add_r3_b",    1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk("nop_b",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk("or_memwb",    1, 1, 3, 1, 1, 6, 1, 0, 0, 0, 0, 2'b00, 2'b10));
        vecs.push_back(mk("lw_r2",       1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk("add_lu_stall",1, 2, 2, 1, 1, 7, 1, 0, 0, 1, 1, 2'b00, 2'b00));
        vecs.push_back(mk("add_lu_retry",1, 2, 2, 1, 1, 7, 1, 0, 0, 0, 0, 2'b10, 2'b10));
        vecs.push_back(mk("nop_c",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk("add_r0",      1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk("sub_use_r0",  1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk("lw_r0",       1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 2'b01, 2'b00));
        vecs.push_back(mk("use_r0_nost", 1, 0, 0, 1, 1, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk("lw_r2_b",     1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk("lu_flush",    1, 2, 2, 1, 1, 7, 1, 0, 1, 0, 1, 2'b00, 2'b00));
        vecs.push_back(mk("after_flush", 1, 2, 7, 1, 1, 8, 1, 0, 0, 0, 0, 2'b10, 2'b00));
        vecs.push_back(mk("add_r3_c",    1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk("add_r3_d",    1, 1, 1, 1, 1, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk("prio_exmem",  1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 0, 2'b01, 2'b01));
        vecs.push_back(mk("use_gating",  1, 3, 4, 0, 1, 6, 1, 0, 0, 0, 0, 2'b00, 2'b01));
        vecs.push_back(mk("lw_r9",       1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk("lu_rs2_stall",1, 1, 9, 1, 1,10, 1, 0, 0, 1, 1, 2'b00, 2'b00));
        vecs.push_back(mk("lu_rs2_retry",1, 1, 9, 1, 1,10, 1, 0, 0, 0, 0, 2'b00, 2'b10));
        vecs.push_back(mk("flush_only",  1,10, 0, 1, 0,11, 1, 0, 1, 0, 1, 2'b00, 2'b00));

        rst = 1'b1;
        applyStimulus(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_sel_a",  32'(bus.fwd_sel_a), 32'd0);
        checkOutput("reset_sel_b",  32'(bus.fwd_sel_b), 32'd0);
        checkOutput("reset_stall",  32'(bus.stall),     32'd0);
        checkOutput("reset_bubble", 32'(bus.bubble_ex), 32'd0);
`ifdef FWD_HAZARD_STATS_EN
        checkOutput("reset_stat_stalls", bus.stat_stalls, 32'd0);
        checkOutput("reset_stat_fwds",   bus.stat_fwds,   32'd0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput({vecs[i].name, "_stall"},  32'(bus.stall),     32'(vecs[i].exp_stall));
            checkOutput({vecs[i].name, "_bubble"}, 32'(bus.bubble_ex), 32'(vecs[i].exp_bubble));
            @(posedge clk);
            #1;
            checkOutput({vecs[i].name, "_sel_a"}, 32'(bus.fwd_sel_a), 32'(vecs[i].exp_a));
            checkOutput({vecs[i].name, "_sel_b"}, 32'(bus.fwd_sel_b), 32'(vecs[i].exp_b));
            @(negedge clk);
        end

`ifdef FWD_HAZARD_STATS_EN
        checkOutput("table_stat_stalls", bus.stat_stalls, 32'd2);
        checkOutput("table_stat_fwds",   bus.stat_fwds,   32'd10);
`endif

        // Reset asserted while a load-use stall is pending.
        applyStimulus(mk("rs_lw", 1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 2'b00, 2'b00));
        @(posedge clk);
        @(negedge clk);
        applyStimulus(mk("rs_use", 1, 2, 2, 1, 1, 7, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        #1;
        checkOutput("pre_reset_stall", 32'(bus.stall), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("post_reset_stall",  32'(bus.stall),     32'd0);
        checkOutput("post_reset_bubble", 32'(bus.bubble_ex), 32'd0);
        checkOutput("post_reset_sel_a",  32'(bus.fwd_sel_a), 32'd0);
        checkOutput("post_reset_sel_b",  32'(bus.fwd_sel_b), 32'd0);
`ifdef FWD_HAZARD_STATS_EN
        checkOutput("post_reset_stat_stalls", bus.stat_stalls, 32'd0);
        checkOutput("post_reset_stat_fwds",   bus.stat_fwds,   32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
